mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max wait cycles for mem_ready per access (1..255).
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013, meaning instruction returned on fetch timeout.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port IM_addr  input  32  CPU fetch address.
REQ-006 SHALL have port DM_OE  input  1  CPU data read request.
REQ-007 SHALL have port DM_WEB  input  4  CPU byte write enables, active-low; 4'hF means no write.
REQ-008 SHALL have port DM_A  input  32  CPU data address.
REQ-009 SHALL have port DM_DI  input  32  CPU store data.
REQ-010 SHALL have port IM_data  output  32  registered fetched instruction to CPU.
REQ-011 SHALL have port DM_DO  output  32  registered load data to CPU.
REQ-012 SHALL have port CPU_STALL  output  1  freezes all CPU pipeline registers when high.
REQ-013 SHALL have port mem_req  output  1  shared memory port request.
REQ-014 SHALL have port mem_we  output  4  byte write enables, active-high.
REQ-015 SHALL have port mem_addr  output  32  shared port address.
REQ-016 SHALL have port mem_wdata  output  32  shared port write data.
REQ-017 SHALL have port mem_ready  input  1  access complete; mem_rdata valid same cycle.
REQ-018 SHALL have port mem_rdata  input  32  shared port read data.
REQ-019 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-020 SHALL implement FSM states IDLE, DATA, INST, DONE; one shared port serves both CPU fetch and data access each CPU step.
REQ-021 IDLE: CPU_STALL=1; latch IM_addr, DM_OE, DM_WEB, DM_A, DM_DI; next DATA if DM_OE=1 or DM_WEB!=4'hF, else INST.
REQ-022 DATA: mem_req=1, mem_addr=latched DM_A, mem_we=~latched DM_WEB, mem_wdata=latched DM_DI; on mem_ready go INST.
REQ-023 DATA read (mem_we==0): DM_DO SHALL load mem_rdata on the mem_ready cycle; on write, DM_DO SHALL hold its value.
REQ-024 DM_OE=1 with DM_WEB!=4'hF SHALL be treated as a write only; no DM_DO update.
REQ-025 INST: mem_req=1, mem_we=0, mem_addr=latched IM_addr, mem_wdata=0; on mem_ready IM_data<=mem_rdata, go DONE.
REQ-026 DONE: CPU_STALL=0 for exactly one cycle, mem_req=0; next IDLE.
REQ-027 CPU_STALL SHALL be 1 in IDLE, DATA, INST; 0 only in DONE.
REQ-028 mem_req, mem_addr, mem_we, mem_wdata SHALL be stable while mem_req=1 and mem_ready=0.
REQ-029 In IDLE and DONE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-030 Latency with zero-wait memory (mem_ready same cycle as mem_req): 4 cycles per step with data access, 3 without.
REQ-031 An 8-bit wait counter SHALL clear on entry to DATA/INST and increment each cycle mem_ready=0.
REQ-032 When counter reaches TIMEOUT without mem_ready: set err=1, abandon access; DATA read gives DM_DO=0, INST gives IM_data=NOP_INST; advance as if mem_ready.
REQ-033 mem_ready in IDLE or DONE SHALL be ignored.
REQ-034 err SHALL stay 1 until rst.

Reset
REQ-035 rst=1 at a clock edge SHALL force state IDLE, IM_data=NOP_INST, DM_DO=0, CPU_STALL=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, err=0, counter=0.
REQ-036 rst mid-access SHALL abandon the access immediately; next cycle mem_req=0; late mem_ready SHALL be ignored.

Verification
REQ-037 Fetch only: IM_addr=32'h100, DM_OE=0, DM_WEB=4'hF, mem_ready tied 1, mem_rdata=32'h00A00093 -> one mem_req cycle with addr 32'h100, IM_data=32'h00A00093, CPU_STALL low 1 cycle in every 3.
REQ-038 Load: DM_OE=1, DM_A=32'h2000, memory returns 32'hDEADBEEF for data then 32'h13 for fetch -> DATA access precedes INST, DM_DO=32'hDEADBEEF, step in 4 cycles.
REQ-039 Store: DM_WEB=4'b1100, DM_A=32'h2004, DM_DI=32'h12345678 -> mem_we=4'b0011, mem_wdata=32'h12345678, DM_DO unchanged.
REQ-040 Wait states: mem_ready asserted after 3 idle cycles -> request signals stable for 4 cycles, CPU_STALL high throughout.
REQ-041 Timeout: TIMEOUT=4, mem_ready never asserted on fetch -> after 4 wait cycles IM_data=32'h13, err=1, DONE reached, err held until rst.
REQ-042 Reset in DATA with mem_ready pending -> next cycle mem_req=0, CPU_STALL=1, err=0, DM_DO=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: time-multiplexes one memory port between CPU data access and instruction fetch.
module mem_port_arbiter #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IM_addr,
  input  logic        DM_OE,
  input  logic [3:0]  DM_WEB,
  input  logic [31:0] DM_A,
  input  logic [31:0] DM_DI,
  output logic [31:0] IM_data,
  output logic [31:0] DM_DO,
  output logic        CPU_STALL,
  output logic        mem_req,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, DATA, INST, DONE} state_t;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  state_t      state;
  logic [31:0] im_addr_q;
  logic        rd_q;
  logic [7:0]  cnt;
  logic        expire;
  logic        hit;
  assign expire = !mem_ready && (cnt == LAST);
  assign hit = mem_ready || expire;
  // Bus outputs are registered, so each transition loads the next access onto the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      im_addr_q <= '0;
      rd_q      <= 1'b0;
      cnt       <= '0;
      IM_data   <= NOP_INST;
      DM_DO     <= '0;
      CPU_STALL <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          im_addr_q <= IM_addr;
          rd_q      <= DM_OE && (DM_WEB == 4'hF);
          cnt       <= '0;
          mem_req   <= 1'b1;
          if (DM_OE || DM_WEB != 4'hF) begin
            state     <= DATA;
            mem_addr  <= DM_A;
            mem_we    <= ~DM_WEB;
            mem_wdata <= DM_DI;
          end else begin
            state     <= INST;
            mem_addr  <= IM_addr;
            mem_we    <= '0;
            mem_wdata <= '0;
          end
        end
        DATA: begin
          if (hit) begin
            if (rd_q) DM_DO <= mem_ready ? mem_rdata : '0;
            if (expire) err <= 1'b1;
            state     <= INST;
            cnt       <= '0;
            mem_addr  <= im_addr_q;
            mem_we    <= '0;
            mem_wdata <= '0;
          end else cnt <= cnt + 8'd1;
        end
        INST: begin
          if (hit) begin
            IM_data   <= mem_ready ? mem_rdata : NOP_INST;
            if (expire) err <= 1'b1;
            state     <= DONE;
            cnt       <= '0;
            CPU_STALL <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
          end else cnt <= cnt + 8'd1;
        end
        default: begin
          state     <= IDLE;
          CPU_STALL <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a wait-state memory model.
module tb_mem_port_arbiter;
  localparam int TO = 4;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [31:0] IM_addr = 0, DM_A = 0, DM_DI = 0;
  logic DM_OE = 0;
  logic [3:0] DM_WEB = 4'hF;
  logic [31:0] IM_data, DM_DO, mem_addr, mem_wdata, mem_rdata;
  logic CPU_STALL, mem_req, mem_ready, err;
  logic [3:0] mem_we;
  int waits = 0;
  bit nev = 0, stray = 0;
  logic [3:0] wcnt = 0;
  int n_chk = 0, n_pass = 0;
  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .IM_addr(IM_addr), .DM_OE(DM_OE), .DM_WEB(DM_WEB),
    .DM_A(DM_A), .DM_DI(DM_DI), .IM_data(IM_data), .DM_DO(DM_DO),
    .CPU_STALL(CPU_STALL), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .err(err)
  );
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'h100:  return 32'h00A00093;
      32'h104:  return 32'h00000013;
      32'h2000: return 32'hDEADBEEF;
      default:  return {a[15:0], ~a[15:0]};
    endcase
  endfunction
  assign mem_rdata = mem_f(mem_addr);
  assign mem_ready = mem_req ? (!nev && wcnt == 4'(waits)) : stray;
  always @(posedge clk) wcnt <= (mem_req && !mem_ready) ? wcnt + 4'd1 : 4'd0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask
  typedef struct {logic [31:0] im, dm; logic er; int len;} step_t;
  typedef struct {logic [31:0] a; logic [3:0] we; logic [31:0] d;} acc_t;
  step_t sq[$];
  acc_t aq[$];
  logic [31:0] im_exp = 32'h13, dm_exp = 0;
  logic err_exp = 0;
  int cyc = 0;
  logic pend = 0;
  logic [31:0] p_addr, p_wdata;
  logic [3:0] p_we;
  always @(negedge clk) begin
    if (rst) begin
      cyc = 0;
      pend = 0;
    end else begin
      cyc++;
      if (!CPU_STALL) begin
        if (sq.size() == 0) check("step_extra", 1, 0);
        else begin
          step_t s;
          s = sq.pop_front();
          check("im_data", IM_data, s.im);
          check("dm_do", DM_DO, s.dm);
          check("err", {31'b0, err}, {31'b0, s.er});
          check("step_len", cyc, s.len);
        end
        cyc = 0;
      end
      if (mem_req) begin
        check("stall_busy", {31'b0, CPU_STALL}, 1);
        if (pend) begin
          check("hold_addr", mem_addr, p_addr);
          check("hold_wdata", mem_wdata, p_wdata);
          check("hold_we", {28'b0, mem_we}, {28'b0, p_we});
        end
        if (mem_ready) begin
          if (aq.size() == 0) check("acc_extra", 1, 0);
          else begin
            acc_t x;
            x = aq.pop_front();
            check("acc_addr", mem_addr, x.a);
            check("acc_we", {28'b0, mem_we}, {28'b0, x.we});
            check("acc_wdata", mem_wdata, x.d);
          end
        end
        pend = !mem_ready;
        p_addr = mem_addr;
        p_wdata = mem_wdata;
        p_we = mem_we;
      end else begin
        check("bus_zero", mem_addr | mem_wdata | {28'b0, mem_we}, 0);
        pend = 0;
      end
    end
  end
  task automatic step(input logic oe, input logic [3:0] web, input logic [31:0] a, d, ia,
                      input int w, input bit nv, input bit sr);
    bit data, fin;
    step_t s;
    @(posedge clk);
    #1;
    rst = 0;
    DM_OE = oe; DM_WEB = web; DM_A = a; DM_DI = d; IM_addr = ia;
    waits = w; nev = nv; stray = sr;
    data = oe || web != 4'hF;
    if (data) begin
      if (!nv) aq.push_back('{a, ~web, d});
      if (web == 4'hF) dm_exp = nv ? 32'h0 : mem_f(a);
      if (nv) err_exp = 1;
    end
    if (!nv) aq.push_back('{ia, 4'h0, 32'h0});
    im_exp = nv ? 32'h13 : mem_f(ia);
    if (nv) err_exp = 1;
    s.im = im_exp; s.dm = dm_exp; s.er = err_exp;
    s.len = 2 + (data ? (nv ? TO : 1 + w) : 0) + (nv ? TO : 1 + w);
    sq.push_back(s);
    fin = 0;
    for (int i = 0; i < 40 && !fin; i++) begin
      @(negedge clk);
      fin = !CPU_STALL;
    end
    if (!fin) check("step_done", 0, 1);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_im", IM_data, 32'h13);
    check("rst_dm", DM_DO, 0);
    check("rst_stall", {31'b0, CPU_STALL}, 1);
    check("rst_req", {31'b0, mem_req}, 0);
    check("rst_err", {31'b0, err}, 0);
    step(0, 4'hF, 0, 0, 32'h100, 0, 0, 0);
    step(0, 4'hF, 0, 0, 32'h100, 0, 0, 0);
    step(1, 4'hF, 32'h2000, 0, 32'h104, 0, 0, 0);
    step(0, 4'b1100, 32'h2004, 32'h12345678, 32'h108, 0, 0, 0);
    step(1, 4'b1110, 32'h2008, 32'hCAFEF00D, 32'h10C, 0, 0, 1);
    step(1, 4'hF, 32'h3000, 0, 32'h110, 3, 0, 1);
    step(0, 4'hF, 0, 0, 32'h114, 3, 0, 0);
    for (int i = 0; i < 12; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF,
           $urandom & 32'hFFFC, $urandom, $urandom & 32'hFFFC, $urandom_range(0, 3), 0,
           1'($urandom_range(0, 1)));
    step(0, 4'hF, 0, 0, 32'h200, 0, 1, 0);
    step(1, 4'hF, 32'h2000, 0, 32'h104, 1, 0, 0);
    step(0, 4'b0000, 32'h4000, 32'h55AA55AA, 32'h204, 2, 0, 0);
    @(posedge clk);
    #1;
    DM_OE = 1; DM_WEB = 4'hF; DM_A = 32'h3000; IM_addr = 32'h208; nev = 1; stray = 0;
    @(negedge clk);
    @(negedge clk);
    check("mid_req", {31'b0, mem_req}, 1);
    check("mid_addr", mem_addr, 32'h3000);
    @(posedge clk);
    #1;
    rst = 1; nev = 0; stray = 1;
    @(posedge clk);
    @(negedge clk);
    check("abort_req", {31'b0, mem_req}, 0);
    check("abort_stall", {31'b0, CPU_STALL}, 1);
    check("abort_err", {31'b0, err}, 0);
    check("abort_dm", DM_DO, 0);
    check("abort_im", IM_data, 32'h13);
    dm_exp = 0; err_exp = 0;
    sq.delete(); aq.delete();
    step(0, 4'hF, 0, 0, 32'h100, 0, 0, 1);
    step(1, 4'hF, 32'h2000, 0, 32'h104, 2, 0, 0);
    @(negedge clk);
    check("sq_empty", sq.size(), 0);
    check("aq_empty", aq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
